// File: rtl/axis_2_ppfifo_packer.sv
// axis_2_ppfifo_packer: packs RATIO narrow stream beats into one wide ping-pong FIFO word
module axis_2_ppfifo_packer #(
  parameter int AXIS_WIDTH   = 8,
  parameter int RATIO        = 4,
  parameter int LANE_W       = (RATIO > 1) ? $clog2(RATIO) : 1,
  parameter int PPFIFO_WIDTH = AXIS_WIDTH * RATIO
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [AXIS_WIDTH-1:0]                i_axis_tdata,
  input  logic                                 i_axis_tlast,
  input  logic                                 i_axis_tvalid,
  output logic                                 o_axis_tready,
  input  logic [1:0]                           i_ppfifo_rdy,
  output logic [1:0]                           o_ppfifo_act,
  input  logic [23:0]                          i_ppfifo_size,
  output logic                                 o_ppfifo_stb,
  output logic [PPFIFO_WIDTH+LANE_W:0]         o_ppfifo_data
);
  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;
  state_t state, state_n;
  logic [LANE_W-1:0] lane;
  logic [23:0] count, size;
  logic last_ch, ch, accept, done;
  logic [RATIO-1:0][AXIS_WIDTH-1:0] lanes, lanes_n;
  // Handshake, channel choice (alternate when both ready), word completion and next state
  always_comb begin
    o_axis_tready = (state == ACTIVE) && (count < size);
    accept = o_axis_tready && i_axis_tvalid;
    done = accept && (i_axis_tlast || lane == LANE_W'(RATIO - 1));
    ch = (i_ppfifo_rdy == 2'b11) ? ~last_ch : i_ppfifo_rdy[1];
    lanes_n = lanes;
    if (accept) lanes_n[lane] = i_axis_tdata;
    state_n = (state == IDLE) ? ((|i_ppfifo_rdy) ? ACTIVE : IDLE) :
              (state == ACTIVE) ? ((size == '0 || (done && (i_axis_tlast || count + 24'd1 == size))) ? RELEASE : ACTIVE) :
              IDLE;
  end
  // State, channel activation and the packing datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      o_ppfifo_act <= '0;
      o_ppfifo_stb <= 1'b0;
      o_ppfifo_data <= '0;
      lane <= '0;
      count <= '0;
      size <= '0;
      lanes <= '0;
      last_ch <= 1'b1;
    end else begin
      state <= state_n;
      o_ppfifo_stb <= done;
      if (state == IDLE && |i_ppfifo_rdy) begin
        o_ppfifo_act <= ch ? 2'b10 : 2'b01;
        last_ch <= ch;
        size <= i_ppfifo_size;
        count <= '0;
      end
      if (state == RELEASE || (state == ACTIVE && size == '0)) o_ppfifo_act <= '0;
      if (accept) begin
        lanes <= done ? '0 : lanes_n;
        lane <= done ? '0 : lane + 1'b1;
      end
      if (done) begin
        o_ppfifo_data <= {lane, i_axis_tlast, lanes_n};
        count <= count + 24'd1;
      end
    end
  end
endmodule

// File: tb/tb_axis_2_ppfifo_packer.sv
// tb_axis_2_ppfifo_packer: directed-vector bench for the stream to ping-pong FIFO packer
module tb_axis_2_ppfifo_packer;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] tdata;
  logic tlast, tvalid, tready, stb;
  logic [1:0] rdy, act;
  logic [23:0] size;
  logic [34:0] data;
  int n_vec = 0;
  int n_bad = 0;
  int act_hi = 0;
  int rdy_hi = 0;
  logic [34:0] stb_q[$];
  logic [1:0] stb_act_q[$];

  axis_2_ppfifo_packer dut (
    .clk(clk), .rst(rst),
    .i_axis_tdata(tdata), .i_axis_tlast(tlast), .i_axis_tvalid(tvalid), .o_axis_tready(tready),
    .i_ppfifo_rdy(rdy), .o_ppfifo_act(act), .i_ppfifo_size(size),
    .o_ppfifo_stb(stb), .o_ppfifo_data(data)
  );

  always #5 clk = ~clk;

  // Record every strobe with its active channel, plus activity counters
  always @(negedge clk) begin
    if (stb) begin
      stb_q.push_back(data);
      stb_act_q.push_back(act);
    end
    if (act != 2'b00) act_hi++;
    if (tready) rdy_hi++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    stb_q.delete();
    stb_act_q.delete();
    act_hi = 0;
    rdy_hi = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_act();
    int w = 0;
    while (act == 2'b00 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("act_timeout", 0, 1);
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    int w = 0;
    tdata = d;
    tlast = l;
    tvalid = 1'b1;
    while (!tready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) chk("tready_timeout", 0, 1);
    @(negedge clk);
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  logic [34:0] exp3[4] = '{35'h604030201, 35'h608070605, 35'h60c0b0a09, 35'h6100f0e0d};
  logic [1:0]  act3[4] = '{2'b01, 2'b01, 2'b10, 2'b10};
  logic [34:0] exp4[4] = '{35'h714131211, 35'h724232221, 35'h734333231, 35'h744434241};
  logic [1:0]  act4[4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    rst = 1'b1;
    tdata = '0;
    tlast = 1'b0;
    tvalid = 1'b0;
    rdy = 2'b00;
    size = 24'd0;
    repeat (3) @(negedge clk);
    chk("rst_act", act, 2'b00);
    chk("rst_stb", stb, 0);
    chk("rst_data", data, 0);
    chk("rst_tready", tready, 0);
    rst = 1'b0;

    clr();
    size = 24'd16;
    rdy = 2'b01;
    wait_act();
    rdy = 2'b00;
    for (int i = 1; i <= 8; i++) beat(8'(i), i == 8);
    repeat (5) @(negedge clk);
    chk("t1_nstb", stb_q.size(), 2);
    if (stb_q.size() == 2) begin
      chk("t1_w0", stb_q[0], 35'h604030201);
      chk("t1_w1", stb_q[1], 35'h708070605);
    end
    chk("t1_act_off", act, 2'b00);

    clr();
    rdy = 2'b01;
    wait_act();
    rdy = 2'b00;
    for (int i = 1; i <= 5; i++) beat(8'(i), i == 5);
    repeat (5) @(negedge clk);
    chk("t2_nstb", stb_q.size(), 2);
    if (stb_q.size() == 2) begin
      chk("t2_w0", stb_q[0], 35'h604030201);
      chk("t2_w1", stb_q[1], 35'h100000005);
    end

    do_reset();
    clr();
    size = 24'd2;
    rdy = 2'b11;
    for (int i = 1; i <= 16; i++) beat(8'(i), 1'b0);
    repeat (3) @(negedge clk);
    rdy = 2'b00;
    chk("t3_nstb", stb_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < stb_q.size()) begin
        chk($sformatf("t3_w%0d", i), stb_q[i], exp3[i]);
        chk($sformatf("t3_act%0d", i), stb_act_q[i], act3[i]);
      end

    do_reset();
    clr();
    size = 24'd16;
    rdy = 2'b11;
    for (int f = 1; f <= 4; f++)
      for (int i = 1; i <= 4; i++) beat(8'(16 * f + i), i == 4);
    repeat (3) @(negedge clk);
    rdy = 2'b00;
    chk("t4_nstb", stb_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < stb_q.size()) begin
        chk($sformatf("t4_w%0d", i), stb_q[i], exp4[i]);
        chk($sformatf("t4_act%0d", i), stb_act_q[i], act4[i]);
      end

    do_reset();
    repeat (2) @(negedge clk);
    clr();
    size = 24'd0;
    rdy = 2'b01;
    wait_act();
    rdy = 2'b00;
    repeat (8) @(negedge clk);
    chk("t5_act_cycles", act_hi, 1);
    chk("t5_nstb", stb_q.size(), 0);
    chk("t5_tready", rdy_hi, 0);

    do_reset();
    clr();
    size = 24'd16;
    rdy = 2'b01;
    wait_act();
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_act_rst", act, 2'b00);
    chk("t6_tready_rst", tready, 0);
    rst = 1'b0;
    wait_act();
    rdy = 2'b00;
    for (int i = 0; i < 4; i++) beat(8'hA0 + 8'(i), 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_nstb", stb_q.size(), 1);
    if (stb_q.size() == 1) chk("t6_w0", stb_q[0], 35'h6A3A2A1A0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
